// File: rtl/btn_step_gen.sv
// btn_step_gen: synchronises and debounces a push-button, then turns each press
// into a single-cycle step strobe with optional auto-repeat while held.
module btn_step_gen #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] HOLD_CYCLES     = 24'd5000000,
    parameter logic [23:0] REPEAT_CYCLES   = 24'd1000000,
    parameter logic        REPEAT_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    input  logic       enable,
    output logic       btn_level,
    output logic       step_pulse,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic        sync1_q;
    logic        sync2_q;
    logic [15:0] db_cnt_q;
    logic [15:0] db_cnt_d;
    logic        level_q;
    logic        level_d;
    state_t      state_q;
    logic [23:0] tmr_q;
    logic        fire_d;
    logic        pulse_q;
    logic [7:0]  count_q;

    // Two-flop synchroniser; the only logic that samples btn_raw
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: accept a new level after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    // Internal fire: decisions look at level_d so the first pulse lands in the cycle
    // btn_level registers 1, and a release in the same cycle as a timer expiry suppresses it
    always_comb begin
        fire_d = 1'b0;
        case (state_q)
            IDLE:    fire_d = level_d;
            HOLD:    fire_d = level_d && REPEAT_EN && (tmr_q == HOLD_CYCLES - 24'd1);
            REPEAT:  fire_d = level_d && (tmr_q == REPEAT_CYCLES - 24'd1);
            default: fire_d = 1'b0;
        endcase
    end

    // Press/hold/repeat FSM with registered strobe and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            pulse_q <= fire_d & enable;
            if (fire_d && enable) begin
                count_q <= count_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (level_d) begin
                        tmr_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!level_d) begin
                        state_q <= IDLE;
                    end else if (fire_d) begin
                        tmr_q   <= '0;
                        state_q <= REPEAT;
                    end else begin
                        tmr_q <= tmr_q + 24'd1;
                    end
                end
                REPEAT: begin
                    if (!level_d) begin
                        state_q <= IDLE;
                    end else if (fire_d) begin
                        tmr_q <= '0;
                    end else begin
                        tmr_q <= tmr_q + 24'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign btn_level  = level_q;
    assign step_pulse = pulse_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_btn_step_gen.sv
// tb_btn_step_gen: table vectors, directed multi-cycle sequences and randomised
// stimulus against a behavioural model, for REPEAT_EN=1 and REPEAT_EN=0 instances.
module tb_btn_step_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic       enable;
    logic       lvl0, pulse0, lvl1, pulse1;
    logic [7:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    btn_step_gen #(
        .DEBOUNCE_CYCLES(16'(DEB)),
        .HOLD_CYCLES(24'(HOLD)),
        .REPEAT_CYCLES(24'(REP)),
        .REPEAT_EN(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .enable(enable),
        .btn_level(lvl0), .step_pulse(pulse0), .step_count(cnt0)
    );

    btn_step_gen #(
        .DEBOUNCE_CYCLES(16'(DEB)),
        .HOLD_CYCLES(24'(HOLD)),
        .REPEAT_CYCLES(24'(REP)),
        .REPEAT_EN(1'b0)
    ) u_dut_norep (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .enable(enable),
        .btn_level(lvl1), .step_pulse(pulse1), .step_count(cnt1)
    );

    // ---------------- behavioural reference model ----------------
    // Level flips once the last DEB synchronised samples all disagree with it.
    // Pulses: at the press, then (repeat variant) at press+HOLD+k*REP while held.
    bit     m_s1, m_s2, m_lvl;
    bit     m_hist[$];
    longint m_cyc, m_t0, m_age;
    bit     m_pulse[2];
    int     m_cnt[2];
    bit     n_lvl, n_press, n_diff, n_fire;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_hist.delete();
            m_cyc = 0; m_t0 = 0;
            for (int m = 0; m < 2; m++) begin
                m_pulse[m] = 0;
                m_cnt[m]   = 0;
            end
        end else begin
            m_cyc++;
            n_lvl = m_lvl;
            m_hist.push_back(m_s2);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            if (m_hist.size() == DEB) begin
                n_diff = 1;
                foreach (m_hist[i]) if (m_hist[i] == m_lvl) n_diff = 0;
                if (n_diff) begin
                    n_lvl = !m_lvl;
                    m_hist.delete();
                end
            end
            n_press = n_lvl && !m_lvl;
            if (n_press) m_t0 = m_cyc;
            m_age = m_cyc - m_t0;
            for (int m = 0; m < 2; m++) begin
                n_fire = n_press ||
                         (m == 0 && n_lvl && m_lvl && m_age >= HOLD && ((m_age - HOLD) % REP) == 0);
                m_pulse[m] = n_fire && (enable === 1'b1);
                if (m_pulse[m]) m_cnt[m]++;
            end
            m_lvl = n_lvl;
            m_s2  = m_s1;
            m_s1  = btn_raw;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("model_level",    32'(lvl0),   32'(m_lvl));
        chk("model_pulse",    32'(pulse0), 32'(m_pulse[0]));
        chk("model_count",    32'(cnt0),   32'(m_cnt[0] % 256));
        chk("model_level_nr", 32'(lvl1),   32'(m_lvl));
        chk("model_pulse_nr", 32'(pulse1), 32'(m_pulse[1]));
        chk("model_count_nr", 32'(cnt1),   32'(m_cnt[1] % 256));
    endtask

    task automatic idle(input int n);
        btn_raw = 1'b0;
        repeat (n) tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       raw;
        logic       en;
        logic       lvl;
        logic       pulse;
        logic [7:0] cnt;
    } vec_t;

    vec_t        vecs[30];
    logic [13:0] bounce_pat;
    int          len;

    initial begin
        // Row r: inputs applied for the cycle, outputs checked after the following edge.
        // Clean press of 8 cycles: level high rows 5..12, one pulse at row 5.
        for (int r = 0; r < 16; r++)
            vecs[r] = '{raw: (r < 8), en: 1'b1, lvl: (r >= 5 && r <= 12),
                        pulse: (r == 5), cnt: (r >= 5) ? 8'd1 : 8'd0};
        // Bounce 3 high / 2 low / 3 high, then low: never accepted.
        bounce_pat = 14'b11100111000000;
        for (int r = 0; r < 14; r++)
            vecs[16 + r] = '{raw: bounce_pat[13 - r], en: 1'b1, lvl: 1'b0,
                             pulse: 1'b0, cnt: 8'd1};

        rst_n = 1'b0; btn_raw = 1'b0; enable = 1'b1;
        repeat (3) tick();
        chk("rst_level", 32'(lvl0), 0);
        chk("rst_pulse", 32'(pulse0), 0);
        chk("rst_count", 32'(cnt0), 0);
        rst_n = 1'b1;
        idle(2);

        // Tests 1 and 2 from the table
        for (int i = 0; i < 30; i++) begin
            btn_raw = vecs[i].raw;
            enable  = vecs[i].en;
            tick();
            chk($sformatf("vec%0d_level", i),    32'(lvl0),   32'(vecs[i].lvl));
            chk($sformatf("vec%0d_pulse", i),    32'(pulse0), 32'(vecs[i].pulse));
            chk($sformatf("vec%0d_count", i),    32'(cnt0),   32'(vecs[i].cnt));
            chk($sformatf("vec%0d_pulse_nr", i), 32'(pulse1), 32'(vecs[i].pulse));
            chk($sformatf("vec%0d_count_nr", i), 32'(cnt1),   32'(vecs[i].cnt));
        end
        idle(4);

        // Tests 3/4: long hold; t0 = edge 6, raw released after edge 30 so
        // btn_level falls at t0+30 together with a would-be repeat (release wins)
        btn_raw = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (e == 30) btn_raw = 1'b0;
            chk("hold_pulse",    32'(pulse0), 32'(e == 6 || e == 16 || e == 21 || e == 26 || e == 31));
            chk("hold_pulse_nr", 32'(pulse1), 32'(e == 6));
        end
        chk("hold_count",    32'(cnt0), 6);
        chk("hold_count_nr", 32'(cnt1), 2);
        idle(4);

        // Test 5: enable low until t0+12
        enable  = 1'b0;
        btn_raw = 1'b1;
        for (int e = 1; e <= 45; e++) begin
            tick();
            if (e == 18) enable = 1'b1;
            if (e == 30) btn_raw = 1'b0;
            chk("en_pulse",    32'(pulse0), 32'(e == 21 || e == 26 || e == 31));
            chk("en_pulse_nr", 32'(pulse1), 0);
        end
        chk("en_count",    32'(cnt0), 9);
        chk("en_count_nr", 32'(cnt1), 2);
        idle(4);

        // Test 6: 256 short presses wrap the counter back to its start value
        for (int p = 0; p < 256; p++) begin
            btn_raw = 1'b1;
            repeat (8) tick();
            idle(10);
        end
        chk("wrap_count",    32'(cnt0), 9);
        chk("wrap_count_nr", 32'(cnt1), 2);

        // Reset at t0+12 of a hold, button kept pressed through reset release
        btn_raw = 1'b1;
        repeat (18) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(lvl0), 0);
        chk("midrst_pulse", 32'(pulse0), 0);
        chk("midrst_count", 32'(cnt0), 0);
        chk("midrst_count_nr", 32'(cnt1), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("postrst_pulse", 32'(pulse0), 32'(e == 6));
            chk("postrst_level", 32'(lvl0),   32'(e >= 6));
            chk("postrst_count", 32'(cnt0),   32'(e >= 6));
        end
        idle(20);

        // Randomised bursts: short glitches, normal presses and long holds
        for (int b = 0; b < 200; b++) begin
            btn_raw = ~btn_raw;
            enable  = ($urandom_range(0, 4) != 0);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                              : int'($urandom_range(1, 8));
            repeat (len) tick();
        end
        enable = 1'b1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/btn_step_gen.md
Name: btn_step_gen

Overview:
- Upstream stage for the 8-bit LFSR stepper. It replaces the raw push-button used as a clock with a clean, single-cycle step strobe on the system clock.
- Synchronises and debounces one push-button input.
- Emits exactly one `step_pulse` per press, plus optional auto-repeat while the button is held.
- The downstream LFSR runs on `clk` and advances only when `step_pulse` = 1.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles needed to accept a new button level; legal range 2..65535.
- HOLD_CYCLES, 24'd5000000: cycles held after the first pulse before auto-repeat starts; legal range 2..2^24-1.
- REPEAT_CYCLES, 24'd1000000: period between auto-repeat pulses; legal range 2..2^24-1.
- REPEAT_EN, 1: 1 enables auto-repeat; 0 gives a single pulse per press.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- btn_raw, input, 1: raw button, asynchronous to `clk`, may bounce; active high.
- enable, input, 1: 0 suppresses `step_pulse`; debounce and FSM keep running.
- btn_level, output, 1: debounced button level.
- step_pulse, output, 1: one-cycle strobe that advances the downstream LFSR.
- step_count, output, 8: count of `step_pulse` assertions, wrapping.

Behaviour:
- Reset (asynchronous assert, synchronous release): sync FFs 0, `btn_level` 0, `step_pulse` 0, `step_count` 8'h00, all counters 0, FSM = IDLE.
- Synchroniser: two-flop chain; `btn_sync` = second flop. No other logic samples `btn_raw`.
- Debounce:
  - `db_cnt` clears in any cycle where `btn_sync` == `btn_level`.
  - Otherwise `db_cnt` increments.
  - When `btn_sync` != `btn_level` and `db_cnt` == DEBOUNCE_CYCLES-1, `btn_level` toggles and `db_cnt` clears.
  - Clean edge on `btn_raw` to `btn_level` change: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at `btn_sync` never changes `btn_level`.
- FSM states: IDLE, HOLD, REPEAT. `tmr` is a 24-bit timer.
  - IDLE: on the cycle `btn_level` registers 1, `step_pulse` = 1 in that same cycle, `tmr` <= 0, next state HOLD.
  - HOLD:
    - `btn_level` = 0 → IDLE, no pulse.
    - Else if REPEAT_EN and `tmr` == HOLD_CYCLES-1: pulse, `tmr` <= 0, → REPEAT.
    - Else `tmr` increments. With REPEAT_EN = 0, stays in HOLD until release.
  - REPEAT:
    - `btn_level` = 0 → IDLE.
    - Else if `tmr` == REPEAT_CYCLES-1: pulse, `tmr` <= 0.
    - Else `tmr` increments.
- Pulse timing: with the first pulse at cycle t0, pulses occur at t0+HOLD_CYCLES, then every REPEAT_CYCLES.
- Pulse rules:
  - `step_pulse` is registered and never high for two consecutive cycles (guaranteed by the legal minimum of 2 for both periods).
  - Pulse qualifier: `step_pulse` = internal fire AND `enable`.
  - FSM and timers advance identically regardless of `enable`.
  - `step_count` increments only on asserted `step_pulse`; 8'hFF → 8'h00.
- Release and press timing:
  - Release is detected only via debounced `btn_level`.
  - A release and a fire in the same cycle give no pulse; release wins.
  - A re-press is accepted only after `btn_level` has returned to 0, so at least 2*DEBOUNCE_CYCLES cycles separate press-pulses.
- Reset mid-hold: all state clears immediately. If the button is still held after release of reset, a new press is seen after 2 + DEBOUNCE_CYCLES cycles and a first pulse is generated.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, REPEAT_EN=1, enable=1 unless stated):
1. Reset, then a clean `btn_raw` 0→1 at cycle 0, held 8 cycles, then 0 → `btn_level` rises at cycle 6; single `step_pulse` at cycle 6; `btn_level` falls 6 cycles after release; `step_count` = 1.
2. Bounce: `btn_raw` toggles with high/low runs of 3, 2, 3 cycles, then stays 0 → `btn_level` stays 0; no pulse; `step_count` = 0.
3. Hold for 30 cycles after `btn_level` rises at t0 → pulses exactly at t0, t0+10, t0+15, t0+20, t0+25; none after release; `step_count` = 5.
4. REPEAT_EN=0, same hold → single pulse at t0; `step_count` = 1.
5. `enable` = 0 during a scenario-3 hold, raised at t0+12 → pulses only at t0+15, t0+20, t0+25; `step_count` = 3.
6. 256 separate clean presses → `step_count` returns to 8'h00. Then assert `rst_n` = 0 at t0+12 of a hold → all outputs 0 immediately; first pulse 6 cycles after `rst_n` release while `btn_raw` is still held.
